// File: rtl/cba_pkg.sv
// ============================================================================
//  Module      : cba_pkg
//  Description : Shared constants and state encoding for the serial adder.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package cba_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cba_state_t;

endpackage

`default_nettype wire

// File: rtl/cba4_slice.sv
// ============================================================================
//  Module      : cba4_slice
//  Description : Combinational 4-bit carry-bypass adder slice.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module cba4_slice
    import cba_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout,
    output logic             skip
);

    logic [NIB_W-1:0] w_p;
    logic [NIB_W-1:0] w_g;
    logic [NIB_W:0]   w_c;

    assign w_p = a ^ b;
    assign w_g = a & b;

    always_comb begin
        w_c    = '0;
        w_c[0] = cin;
        for (int i = 0; i < NIB_W; i++) begin
            w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
        end
    end

    assign sum  = w_p ^ w_c[NIB_W-1:0];
    assign skip = &w_p;
    // When every bit propagates, the incoming carry skips the ripple chain.
    assign cout = skip ? cin : w_c[NIB_W];

endmodule

`default_nettype wire

// File: rtl/cba_serial_adder.sv
// ============================================================================
//  Module      : cba_serial_adder
//  Description : Digit-serial adder sequencing one nibble per cycle through a
//                single carry-bypass slice, with valid/ready in and out.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module cba_serial_adder
    import cba_pkg::*;
#(
    parameter  int WIDTH   = 16,
    localparam int NIBBLES = WIDTH / NIB_W,
    localparam int CW      = $clog2(NIBBLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [CW-1:0]    bypass_cnt
);

    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    cba_state_t       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic [CW-1:0]    r_bypass_cnt;

    logic [NIB_W-1:0] w_a_nib;
    logic [NIB_W-1:0] w_b_nib;
    logic [NIB_W-1:0] w_slice_sum;
    logic             w_slice_cout;
    logic             w_skip;
    logic             w_last;

    assign w_a_nib = r_a[r_idx*NIB_W +: NIB_W];
    assign w_b_nib = r_b[r_idx*NIB_W +: NIB_W];
    assign w_last  = (r_idx == IW'(NIBBLES - 1));

    cba4_slice u_slice (
        .a    (w_a_nib),
        .b    (w_b_nib),
        .cin  (r_carry),
        .sum  (w_slice_sum),
        .cout (w_slice_cout),
        .skip (w_skip)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_carry      <= 1'b0;
            r_idx        <= '0;
            r_sum        <= '0;
            r_cout       <= 1'b0;
            r_bypass_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a          <= a;
                        r_b          <= b;
                        r_carry      <= cin;
                        r_idx        <= '0;
                        r_sum        <= '0;
                        r_bypass_cnt <= '0;
                        r_state      <= RUN;
                    end
                end
                RUN: begin
                    r_sum[r_idx*NIB_W +: NIB_W] <= w_slice_sum;
                    r_carry                     <= w_slice_cout;
                    if (w_skip) begin
                        r_bypass_cnt <= r_bypass_cnt + CW'(1);
                    end
                    // idx parks on the top nibble so it never wraps past it.
                    if (w_last) begin
                        r_cout  <= w_slice_cout;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == IDLE) && !rst;
    assign out_valid  = (r_state == DONE);
    assign sum        = r_sum;
    assign cout       = r_cout;
    assign bypass_cnt = r_bypass_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cba_serial_adder.sv
// ============================================================================
//  Module      : tb_cba_serial_adder
//  Description : Self-checking bench for cba_serial_adder (WIDTH=16).
//  Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cba_serial_adder;

    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;
    localparam int CW      = $clog2(NIBBLES + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [CW-1:0]    bypass_cnt;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic [CW-1:0]    bcnt;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    cba_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sum        (sum),
        .cout       (cout),
        .bypass_cnt (bypass_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] fa, input logic [WIDTH-1:0] fb,
                                   input logic fc);
        exp_t             e;
        logic [WIDTH:0]   s;
        logic [WIDTH-1:0] x;
        int               n;
        s = {1'b0, fa} + {1'b0, fb} + {{WIDTH{1'b0}}, fc};
        x = fa ^ fb;
        n = 0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (x[i*4 +: 4] == 4'hF) n++;
        end
        e.sum  = s[WIDTH-1:0];
        e.cout = s[WIDTH];
        e.bcnt = CW'(n);
        return e;
    endfunction

    task automatic pop_chk(input string tag);
        exp_t e;
        chk({tag, "_pending"}, q.size(), 1);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({tag, "_sum"},  sum,        e.sum);
            chk({tag, "_cout"}, cout,       e.cout);
            chk({tag, "_bcnt"}, bypass_cnt, e.bcnt);
        end
    endtask

    // One operation: checks latency, optional back-pressure hold, then drain.
    task automatic directed(input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db,
                            input logic dc, input int hold, input string tag);
        int   lat;
        exp_t e;
        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready, 1);
        in_valid  = 1'b1;
        a         = da;
        b         = db;
        cin       = dc;
        out_ready = (hold == 0);
        e = model(da, db, dc);
        q.push_back(e);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            in_valid = 1'b0;
            a        = WIDTH'($urandom);
            b        = WIDTH'($urandom);
            cin      = 1'($urandom);
            if (!out_valid) chk({tag, "_busy"}, in_ready, 0);
        end while (!out_valid && lat < 20);
        chk({tag, "_latency"}, lat, NIBBLES + 1);
        for (int i = 0; i < hold; i++) begin
            chk({tag, "_hold_sum"},   sum,        e.sum);
            chk({tag, "_hold_cout"},  cout,       e.cout);
            chk({tag, "_hold_bcnt"},  bypass_cnt, e.bcnt);
            chk({tag, "_hold_valid"}, out_valid,  1);
            chk({tag, "_hold_ready"}, in_ready,   0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        pop_chk(tag);
        @(negedge clk);
        chk({tag, "_after_valid"}, out_valid, 0);
        chk({tag, "_after_ready"}, in_ready,  1);
        out_ready = 1'b0;
    endtask

    initial begin
        int accepted;
        int cyc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  in_ready,   0);
        chk("rst_out_valid", out_valid,  0);
        chk("rst_sum",       sum,        0);
        chk("rst_cout",      cout,       0);
        chk("rst_bcnt",      bypass_cnt, 0);

        // Reset and in_valid together: nothing may be accepted.
        in_valid = 1'b1;
        a        = 16'h1111;
        b        = 16'h2222;
        @(negedge clk);
        chk("rst_vs_valid_in_ready", in_ready, 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        for (int i = 0; i < NIBBLES + 2; i++) begin
            @(negedge clk);
            chk("rst_vs_valid_no_out", out_valid, 0);
        end

        directed(16'h1234, 16'h4321, 1'b0, 0, "op1234");
        directed(16'hFFFF, 16'h0000, 1'b1, 0, "opFFFF");
        directed(16'h0F0F, 16'hF0F0, 1'b0, 0, "op0F0F");
        directed(16'h8000, 16'h8000, 1'b0, 5, "op8000_hold");

        // Reset in the middle of RUN abandons the operation.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 16'hFFFF;
        b        = 16'h0001;
        cin      = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("midrst_run_valid0", out_valid, 0);
        repeat (2) @(negedge clk);
        chk("midrst_run_valid2", out_valid, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", out_valid,  0);
        chk("midrst_sum",       sum,        0);
        chk("midrst_cout",      cout,       0);
        chk("midrst_bcnt",      bypass_cnt, 0);
        chk("midrst_in_ready",  in_ready,   0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_release_ready", in_ready,  1);
        chk("midrst_release_valid", out_valid, 0);

        directed(16'h00FF, 16'h0001, 1'b0, 0, "op00FF");

        // Randomised back-to-back traffic with random consumer stalls.
        accepted = 0;
        cyc      = 0;
        while ((accepted < 1000 || q.size() > 0) && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            in_valid  = (accepted < 1000) && ($urandom_range(0, 3) != 0);
            a         = WIDTH'($urandom);
            b         = WIDTH'($urandom);
            cin       = 1'($urandom);
            out_ready = 1'($urandom);
            #1;
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, cin));
                accepted++;
            end
            if (out_valid && out_ready) pop_chk("rand");
        end
        in_valid = 1'b0;
        chk("rand_accepted", accepted, 1000);
        chk("rand_drained",  q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
